// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e     : MDUOp encodings (4 bits)
//   - mdu_state_e  : FSM states IDLE/BUSY
//   - mdu_cnt_w()  : latency counter width, clog2(max(MULT,DIV cycles)) + 1
//   - mdu_is_mult(), mdu_is_div() : classify multi-cycle ops
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10).
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_OP_W = 4;

  function automatic int mdu_cnt_w(input int mult_cycles, input int div_cycles);
    return $clog2((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1;
  endfunction

  // Ops that run for MULT_CYCLES; the accumulate family only exists when enabled.
  function automatic logic mdu_is_mult(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage handshake between the pipeline and the multiply/divide unit.
//   A, B   : rs / rt operands            (master -> slave)
//   MDUOp  : operation code, mdu_op_e    (master -> slave)
//   Start  : launch MDUOp this cycle     (master -> slave)
//   Busy   : operation in flight         (slave -> master)
//   HI, LO : architectural HI/LO values  (slave -> master)
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       MDUOp;
  logic             Start;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, output B, output MDUOp, output Start,
                  input  Busy, input HI, input LO);
  modport slave  (input  A, input B, input MDUOp, input Start,
                  output Busy, output HI, output LO);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for the multiply/divide unit.
// Inputs : op, a, b (latched operands), hi, lo (current HI/LO)
// Outputs: hi_o, lo_o (next HI/LO), we (0 on divide by zero or non-arith op)
// Optional feature macro: MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    hi,
  input  logic [WIDTH-1:0]    lo,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o,
  output logic                we
);

  localparam int W2 = 2 * WIDTH;

  logic signed [W2-1:0]    prod_s;
  logic        [W2-1:0]    prod_u;
  logic                    div_zero;
  logic                    div_ovf;
  logic signed [WIDTH-1:0] sdiv_b;
  logic        [WIDTH-1:0] udiv_b;
  logic signed [WIDTH-1:0] quot_s;
  logic signed [WIDTH-1:0] rem_s;
  logic        [WIDTH-1:0] quot_u;
  logic        [WIDTH-1:0] rem_u;
`ifdef MDU_MADD_EN
  logic        [W2-1:0]    acc;
`endif

  always_comb begin
    // Operands extended to full product width so the 2W-bit result is exact.
    prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_zero = (b == '0);
    div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    // Dividing by 1 instead of 0 or -1 keeps the divider defined and yields
    // exactly the required overflow result (quot = A, rem = 0).
    sdiv_b = (div_zero || div_ovf) ? WIDTH'(1) : $signed(b);
    udiv_b = div_zero ? WIDTH'(1) : b;
    quot_s = $signed(a) / sdiv_b;
    rem_s  = $signed(a) % sdiv_b;
    quot_u = a / udiv_b;
    rem_u  = a % udiv_b;
`ifdef MDU_MADD_EN
    acc    = {hi, lo};
`endif

    hi_o = hi;
    lo_o = lo;
    we   = 1'b0;
    case (op)
      MDU_MULT:  begin {hi_o, lo_o} = prod_s; we = 1'b1; end
      MDU_MULTU: begin {hi_o, lo_o} = prod_u; we = 1'b1; end
      MDU_DIV: begin
        hi_o = rem_s;
        lo_o = quot_s;
        we   = !div_zero;
      end
      MDU_DIVU: begin
        hi_o = rem_u;
        lo_o = quot_u;
        we   = !div_zero;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin {hi_o, lo_o} = acc + prod_s; we = 1'b1; end
      MDU_MADDU: begin {hi_o, lo_o} = acc + prod_u; we = 1'b1; end
      MDU_MSUB:  begin {hi_o, lo_o} = acc - prod_s; we = 1'b1; end
      MDU_MSUBU: begin {hi_o, lo_o} = acc - prod_u; we = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears FSM, counter, Busy, HI, LO
//   bus    : mdu_if.slave  (A, B, MDUOp, Start in; Busy, HI, LO out)
// Parameters: WIDTH, MULT_CYCLES (>=1), DIV_CYCLES (>=1).
// Optional feature macro: MDU_MADD_EN enables ops 7-10 (multiply-accumulate/subtract).
// A multi-cycle op started in cycle n holds Busy in n+1..n+N and updates HI/LO on the
// edge ending n+N. Starts while busy are ignored. MTHI/MTLO write on the next edge.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int CNT_W = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic [WIDTH-1:0]    res_hi;
  logic [WIDTH-1:0]    res_lo;
  logic                res_we;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi_q),
    .lo   (lo_q),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .we   (res_we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (mdu_is_mult(bus.MDUOp) || mdu_is_div(bus.MDUOp)) begin
            state_d = BUSY;
            op_d    = bus.MDUOp;
            a_d     = bus.A;
            b_d     = bus.B;
            cnt_d   = mdu_is_div(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (bus.MDUOp == MDU_MTHI) begin
            hi_d = bus.A;
          end else if (bus.MDUOp == MDU_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      BUSY: begin
        // Start is deliberately not looked at here: the pipeline stalls on Busy.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
    // Operand latches carry no reset: they are only consumed while BUSY.
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. The driver computes the
// expected Busy/HI/LO for each future cycle from an arithmetic reference model and
// queues it; a monitor on the falling edge pops and compares the entries due.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  int           busy_until = -1;

  function automatic int latency(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MC;
      4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference arithmetic on plain 64-bit / int values.
  function automatic logic [2*W-1:0] ref_result(input logic [3:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] hi, input logic [W-1:0] lo, output logic wr);
    longint       ps;
    logic [63:0]  pu;
    int           sa, sbv, q, r;
    ps  = longint'($signed(a)) * longint'($signed(b));
    pu  = {32'h0, a} * {32'h0, b};
    wr  = 1'b1;
    sa  = $signed(a);
    sbv = $signed(b);
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 0) begin wr = 1'b0; return {hi, lo}; end
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      4'd4: begin
        if (b == 0) begin wr = 1'b0; return {hi, lo}; end
        return {a % b, a / b};
      end
      4'd7:  return {hi, lo} + ps;
      4'd8:  return {hi, lo} + pu;
      4'd9:  return {hi, lo} - ps;
      4'd10: return {hi, lo} - pu;
      default: begin wr = 1'b0; return {hi, lo}; end
    endcase
  endfunction

  task automatic push(input int due, input logic busy, input logic [W-1:0] hi,
                      input logic [W-1:0] lo);
    exp_t e;
    e.due = due; e.busy = busy; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus; queues the expectations this cycle implies.
  task automatic step(input logic st, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    int             n, lat;
    logic [2*W-1:0] r;
    logic           wr;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.Start = st;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    n = cyc;
    if (!st || n <= busy_until) return;
    lat = latency(op);
    if (lat > 0) begin
      r = ref_result(op, a, b, hi_m, lo_m, wr);
      for (int c = n + 1; c <= n + lat; c++) push(c, 1'b1, hi_m, lo_m);
      if (wr) {hi_m, lo_m} = r;
      push(n + lat + 1, 1'b0, hi_m, lo_m);
      busy_until = n + lat;
    end else begin
      if (op == 4'd5) hi_m = a;
      else if (op == 4'd6) lo_m = a;
      push(n + 1, 1'b0, hi_m, lo_m);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 4'd0, '0, '0);
  endtask

  task automatic do_reset();
    int   r;
    exp_t keep[$];
    @(posedge clk); #1;
    reset     = 1'b1;
    bus.Start = 1'b0;
    r = cyc;
    foreach (sb[i]) if (sb[i].due <= r) keep.push_back(sb[i]);
    sb = keep;
    hi_m = '0;
    lo_m = '0;
    busy_until = -1;
    push(r + 1, 1'b0, '0, '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return 32'h7FFFFFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL lost_entry due=%0d now=%0d", e.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.Busy !== e.busy || bus.HI !== e.hi || bus.LO !== e.lo) begin
          n_bad++;
          $display("FAIL cycle%0d busy/hi/lo actual=%b/%h/%h required=%b/%h/%h",
                   cyc, bus.Busy, bus.HI, bus.LO, e.busy, e.hi, e.lo);
        end
      end
    end
  end

  // Driver
  initial begin
    bus.Start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A     = '0;
    bus.B     = '0;
    do_reset();
    idle(2);

    step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3);                 // MULT -2*3
    idle(MC + 2);
    step(1'b1, 4'd4, 32'd7, 32'd2);                        // DIVU 7/2
    idle(DC + 2);
    step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2);                 // DIV -7/2
    idle(DC + 2);
    step(1'b1, 4'd5, 32'h12345678, 32'd0);                 // MTHI
    idle(1);
    step(1'b1, 4'd1, 32'd5, 32'd6);                        // MULT, then starts while busy
    step(1'b1, 4'd6, 32'h0000DEAD, 32'd0);
    step(1'b1, 4'd1, 32'd9, 32'd9);
    step(1'b1, 4'd5, 32'd1, 32'd0);
    idle(MC);
    step(1'b1, 4'd5, 32'hAA, 32'd0);                       // divide by zero keeps HI/LO
    step(1'b1, 4'd6, 32'hBB, 32'd0);
    step(1'b1, 4'd3, 32'd123, 32'd0);
    idle(DC + 2);
    step(1'b1, 4'd4, 32'd55, 32'd0);
    idle(DC + 2);
    step(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF);          // signed overflow
    idle(DC + 2);
    step(1'b1, 4'd3, 32'd100, 32'd7);                      // reset in 3rd busy cycle
    idle(2);
    do_reset();
    step(1'b1, 4'd1, 32'd12345, 32'hFFFFFFFD);
    idle(MC + 2);
    step(1'b1, 4'd5, 32'h0, 32'd0);                        // op 7 / MADDU wrap
    step(1'b1, 4'd6, 32'hFFFFFFFF, 32'd0);
    step(1'b1, 4'd8, 32'd1, 32'd1);
    idle(MC + 2);
    step(1'b1, 4'd7, 32'hFFFFFFFF, 32'd3);
    idle(MC + 2);
    step(1'b1, 4'd0, 32'd4, 32'd4);                        // NOP and reserved
    step(1'b1, 4'd15, 32'd4, 32'd4);
    idle(2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick());
    end

    idle(DC + 3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain actual=%0d pending required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
